// File: rtl/regex_cpu_split.sv
// Regex execution unit: runs one (pc, cc_id) thread through code memory until it dies, forks or accepts.
// Supports MATCH/NOT_MATCH/MATCH_ANY, full/partial ACCEPT, JMP, SPLIT and a jump-loop watchdog.
module regex_cpu_split #(
  parameter int unsigned PC_WIDTH          = 9,
  parameter int unsigned CC_ID_BITS        = 2,
  parameter int unsigned CHARACTER_WIDTH   = 8,
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned LOOP_LIMIT        = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]    current_characters,
  input  logic [(2**CC_ID_BITS)-1:0]                    end_of_string,
  input  logic                                          input_pc_valid,
  output logic                                          input_pc_ready,
  input  logic [PC_WIDTH-1:0]                           input_pc,
  input  logic [CC_ID_BITS-1:0]                         input_cc_id,
  output logic                                          memory_valid,
  input  logic                                          memory_ready,
  output logic [MEMORY_ADDR_WIDTH-1:0]                  memory_addr,
  input  logic [MEMORY_WIDTH-1:0]                       memory_data,
  output logic                                          output_pc_valid,
  input  logic                                          output_pc_ready,
  output logic [PC_WIDTH-1:0]                           output_pc,
  output logic [CC_ID_BITS-1:0]                         output_cc_id,
  output logic                                          accepts,
  output logic [CC_ID_BITS-1:0]                         accepts_cc_id,
  output logic                                          accepts_partial,
  output logic                                          error
);

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned CNT_WIDTH    = $clog2(LOOP_LIMIT + 1);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ACCEPT         = 3'd0,
    OP_ACCEPT_PARTIAL = 3'd1,
    OP_MATCH          = 3'd2,
    OP_NOT_MATCH      = 3'd3,
    OP_MATCH_ANY      = 3'd4,
    OP_JMP            = 3'd5,
    OP_SPLIT          = 3'd6
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_EXEC      = 3'd3,
    S_OUTPUT    = 3'd4
  } state_e;

  state_e                     state;
  logic [PC_WIDTH-1:0]        pc;
  logic [CC_ID_BITS-1:0]      cc_id;
  logic [MEMORY_WIDTH-1:0]    instr;
  logic [CNT_WIDTH-1:0]       loop_count;

  logic [OPCODE_WIDTH-1:0]    opcode;
  logic [PC_WIDTH-1:0]        target;
  logic [CHARACTER_WIDTH-1:0] literal;
  logic [CHARACTER_WIDTH-1:0] char_c;
  logic                       eos;
  logic                       watchdog_hit;
  logic [PC_WIDTH-1:0]        pc_inc;
  logic [CC_ID_BITS-1:0]      cc_inc;
  logic                       unused_instr;

  assign opcode       = instr[MEMORY_WIDTH-1 -: OPCODE_WIDTH];
  assign target       = instr[PC_WIDTH-1:0];
  assign literal      = instr[CHARACTER_WIDTH-1:0];
  assign char_c       = current_characters[cc_id*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign eos          = end_of_string[cc_id];
  assign watchdog_hit = (loop_count == CNT_WIDTH'(LOOP_LIMIT - 1));
  assign pc_inc       = pc + PC_WIDTH'(1);
  assign cc_inc       = cc_id + CC_ID_BITS'(1);
  assign unused_instr = ^instr;

  // Thread FSM; EXEC defaults to dropping the thread and returning to IDLE, opcodes override.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      cc_id           <= '0;
      instr           <= '0;
      loop_count      <= '0;
      input_pc_ready  <= 1'b1;
      memory_valid    <= 1'b0;
      memory_addr     <= '0;
      output_pc_valid <= 1'b0;
      output_pc       <= '0;
      output_cc_id    <= '0;
      accepts         <= 1'b0;
      accepts_cc_id   <= '0;
      accepts_partial <= 1'b0;
      error           <= 1'b0;
    end else begin
      accepts <= 1'b0;
      error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (input_pc_valid && input_pc_ready) begin
            pc             <= input_pc;
            cc_id          <= input_cc_id;
            loop_count     <= '0;
            input_pc_ready <= 1'b0;
            memory_valid   <= 1'b1;
            memory_addr    <= MEMORY_ADDR_WIDTH'(input_pc);
            state          <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (memory_ready) begin
            memory_valid <= 1'b0;
            state        <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          instr <= memory_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          state          <= S_IDLE;
          input_pc_ready <= 1'b1;
          case (opcode)
            OP_ACCEPT: begin
              if (eos) begin
                accepts         <= 1'b1;
                accepts_partial <= 1'b0;
                accepts_cc_id   <= cc_id;
              end
            end
            OP_ACCEPT_PARTIAL: begin
              accepts         <= 1'b1;
              accepts_partial <= 1'b1;
              accepts_cc_id   <= cc_id;
            end
            OP_MATCH, OP_NOT_MATCH, OP_MATCH_ANY: begin
              if (!eos && ((opcode == OP_MATCH_ANY) ||
                           ((opcode == OP_MATCH) == (char_c == literal)))) begin
                output_pc_valid <= 1'b1;
                output_pc       <= pc_inc;
                output_cc_id    <= cc_inc;
                input_pc_ready  <= 1'b0;
                state           <= S_OUTPUT;
              end
            end
            OP_JMP: begin
              if (watchdog_hit) begin
                error <= 1'b1;
              end else begin
                pc             <= target;
                loop_count     <= loop_count + CNT_WIDTH'(1);
                memory_valid   <= 1'b1;
                memory_addr    <= MEMORY_ADDR_WIDTH'(target);
                input_pc_ready <= 1'b0;
                state          <= S_FETCH;
              end
            end
            OP_SPLIT: begin
              output_pc_valid <= 1'b1;
              output_pc       <= pc_inc;
              output_cc_id    <= cc_id;
              input_pc_ready  <= 1'b0;
              state           <= S_OUTPUT;
            end
            default: error <= 1'b1;
          endcase
        end
        S_OUTPUT: begin
          // A SPLIT continues at its jump target once the forked branch has been handed off.
          if (output_pc_ready) begin
            output_pc_valid <= 1'b0;
            if (opcode == OP_SPLIT && !watchdog_hit) begin
              pc           <= target;
              loop_count   <= loop_count + CNT_WIDTH'(1);
              memory_valid <= 1'b1;
              memory_addr  <= MEMORY_ADDR_WIDTH'(target);
              state        <= S_FETCH;
            end else begin
              error          <= (opcode == OP_SPLIT);
              input_pc_ready <= 1'b1;
              state          <= S_IDLE;
            end
          end
        end
        default: begin
          input_pc_ready <= 1'b1;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regex_cpu_split.sv
// Directed and randomised checks of regex_cpu_split against hand-computed results and a small opcode model.
module tb_regex_cpu_split;

  localparam logic [2:0] OP_ACC = 3'd0, OP_ACCP = 3'd1, OP_MATCH = 3'd2, OP_NMATCH = 3'd3,
                         OP_ANY = 3'd4, OP_JMP = 3'd5, OP_SPLIT = 3'd6, OP_BAD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] current_characters = 32'h64616263;
  logic [3:0]  end_of_string = 4'b0000;
  logic        input_pc_valid = 1'b0;
  logic        input_pc_ready;
  logic [8:0]  input_pc = '0;
  logic [1:0]  input_cc_id = '0;
  logic        memory_valid;
  logic        memory_ready = 1'b1;
  logic [10:0] memory_addr;
  logic [15:0] memory_data = '0;
  logic        output_pc_valid;
  logic        output_pc_ready = 1'b1;
  logic [8:0]  output_pc;
  logic [1:0]  output_cc_id;
  logic        accepts;
  logic [1:0]  accepts_cc_id;
  logic        accepts_partial;
  logic        error;

  regex_cpu_split dut (
    .clk(clk), .rst(rst), .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_pc_ready(input_pc_ready), .input_pc(input_pc),
    .input_cc_id(input_cc_id), .memory_valid(memory_valid), .memory_ready(memory_ready),
    .memory_addr(memory_addr), .memory_data(memory_data), .output_pc_valid(output_pc_valid),
    .output_pc_ready(output_pc_ready), .output_pc(output_pc), .output_cc_id(output_cc_id),
    .accepts(accepts), .accepts_cc_id(accepts_cc_id), .accepts_partial(accepts_partial), .error(error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  bit   rand_bp  = 1'b0;
  logic out_hold = 1'b1;

  always @(posedge clk) if (memory_valid && memory_ready) memory_data <= mem[memory_addr];

  always @(negedge clk) begin
    if (rand_bp) begin
      memory_ready    = 1'($urandom_range(0, 1));
      output_pc_ready = 1'($urandom_range(0, 1));
    end else begin
      memory_ready    = 1'b1;
      output_pc_ready = out_hold;
    end
  end

  // Event log sampled at each edge; checks use deltas against a per-thread snapshot.
  int          fetch_n = 0, acc_n = 0, fwd_n = 0, err_n = 0;
  logic [10:0] fetch_addr;
  logic        acc_part;
  logic [1:0]  acc_cc, fwd_cc;
  logic [8:0]  fwd_pc;
  always @(posedge clk) begin
    if (memory_valid && memory_ready) begin fetch_n++; fetch_addr = memory_addr; end
    if (accepts) begin acc_n++; acc_part = accepts_partial; acc_cc = accepts_cc_id; end
    if (output_pc_valid && output_pc_ready) begin fwd_n++; fwd_pc = output_pc; fwd_cc = output_cc_id; end
    if (error) err_n++;
  end

  int n_checks = 0, n_mis = 0;
  int b_fetch, b_acc, b_fwd, b_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] d);
    return {op, d};
  endfunction

  task automatic start_thread(input logic [8:0] pc, input logic [1:0] cc);
    b_fetch = fetch_n; b_acc = acc_n; b_fwd = fwd_n; b_err = err_n;
    @(negedge clk);
    input_pc = pc; input_cc_id = cc; input_pc_valid = 1'b1;
    @(posedge clk); #1;
    input_pc_valid = 1'b0;
  endtask

  task automatic finish_thread(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (accepts && output_pc_valid) begin
        n_mis++;
        $display("FAIL %s excl: accepts and output_pc_valid both 1, want not both", name);
      end
      if (input_pc_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin n_mis++; $display("FAIL %s timeout: input_pc_ready 0, want 1", name); end
  endtask

  task automatic check_result(input string name, input logic [8:0] pc, input logic [1:0] cc,
                              input logic e_acc, input logic e_part, input logic e_fwd,
                              input logic [8:0] e_pc, input logic [1:0] e_cc, input logic e_err);
    check({name, " fetch_addr"}, 32'(fetch_addr), 32'(pc));
    check({name, " acc_n"}, 32'(acc_n - b_acc), 32'(e_acc));
    if (e_acc) begin
      check({name, " partial"}, 32'(acc_part), 32'(e_part));
      check({name, " acc_cc"}, 32'(acc_cc), 32'(cc));
    end
    check({name, " fwd_n"}, 32'(fwd_n - b_fwd), 32'(e_fwd));
    if (e_fwd) begin
      check({name, " fwd_pc"}, 32'(fwd_pc), 32'(e_pc));
      check({name, " fwd_cc"}, 32'(fwd_cc), 32'(e_cc));
    end
    check({name, " err_n"}, 32'(err_n - b_err), 32'(e_err));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [12:0] data;
    logic [8:0]  pc;
    logic [1:0]  cc;
    logic [3:0]  eos;
    logic        e_acc, e_part, e_fwd;
    logic [8:0]  e_pc;
    logic [1:0]  e_cc;
    logic        e_err;
  } vec_t;

  vec_t vt [11];

  initial begin
    // Slots: 0='c' 1='b' 2='a' 3='d'
    vt[0]  = '{OP_ACC,    13'h000, 9'h005, 2'd0, 4'b0001, 1, 0, 0, 9'h000, 2'd0, 0};
    vt[1]  = '{OP_ACC,    13'h000, 9'h006, 2'd1, 4'b0001, 0, 0, 0, 9'h000, 2'd0, 0};
    vt[2]  = '{OP_ACCP,   13'h000, 9'h007, 2'd3, 4'b0000, 1, 1, 0, 9'h000, 2'd0, 0};
    vt[3]  = '{OP_MATCH,  13'h061, 9'h1FF, 2'd2, 4'b0000, 0, 0, 1, 9'h000, 2'd3, 0};
    vt[4]  = '{OP_MATCH,  13'h062, 9'h01A, 2'd2, 4'b0000, 0, 0, 0, 9'h000, 2'd0, 0};
    vt[5]  = '{OP_MATCH,  13'h061, 9'h01B, 2'd2, 4'b0100, 0, 0, 0, 9'h000, 2'd0, 0};
    vt[6]  = '{OP_NMATCH, 13'h061, 9'h020, 2'd1, 4'b0000, 0, 0, 1, 9'h021, 2'd2, 0};
    vt[7]  = '{OP_NMATCH, 13'h062, 9'h022, 2'd1, 4'b0000, 0, 0, 0, 9'h000, 2'd0, 0};
    vt[8]  = '{OP_ANY,    13'h000, 9'h030, 2'd3, 4'b0000, 0, 0, 1, 9'h031, 2'd0, 0};
    vt[9]  = '{OP_ANY,    13'h000, 9'h032, 2'd3, 4'b1000, 0, 0, 0, 9'h000, 2'd0, 0};
    vt[10] = '{OP_BAD,    13'h000, 9'h050, 2'd0, 4'b0000, 0, 0, 0, 9'h000, 2'd0, 1};
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst ready", 32'(input_pc_ready), 32'd1);
    check("rst outs", 32'({memory_valid, output_pc_valid, accepts, error}), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      mem[vt[i].pc] = mk(vt[i].op, vt[i].data);
      end_of_string = vt[i].eos;
      start_thread(vt[i].pc, vt[i].cc);
      finish_thread($sformatf("vec%0d", i));
      check_result($sformatf("vec%0d", i), vt[i].pc, vt[i].cc, vt[i].e_acc, vt[i].e_part,
                   vt[i].e_fwd, vt[i].e_pc, vt[i].e_cc, vt[i].e_err);
    end
    end_of_string = 4'b0000;

    // SPLIT: fork (pc+1, cc) then continue at target, which accepts partially
    mem[9'h010] = mk(OP_SPLIT, 13'h040);
    mem[9'h040] = mk(OP_ACCP, 13'h000);
    start_thread(9'h010, 2'd1);
    finish_thread("split");
    check_result("split", 9'h040, 2'd1, 1, 1, 1, 9'h011, 2'd1, 0);
    check("split fetches", 32'(fetch_n - b_fetch), 32'd2);

    // JMP to itself trips the watchdog after LOOP_LIMIT fetches
    mem[9'h080] = mk(OP_JMP, 13'h080);
    start_thread(9'h080, 2'd0);
    finish_thread("jmploop");
    check_result("jmploop", 9'h080, 2'd0, 0, 0, 0, 9'h000, 2'd0, 1);
    check("jmploop fetches", 32'(fetch_n - b_fetch), 32'd16);

    // Output back-pressure: forwarded thread held stable for 5 cycles
    mem[9'h1FF] = mk(OP_MATCH, 13'h061);
    out_hold = 1'b0;
    start_thread(9'h1FF, 2'd2);
    for (int i = 0; i < 50 && !output_pc_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall hold", 32'({output_pc_valid, output_pc, output_cc_id}), 32'({1'b1, 9'h000, 2'd3}));
    end
    out_hold = 1'b1;
    finish_thread("stall");
    check_result("stall", 9'h1FF, 2'd2, 0, 0, 1, 9'h000, 2'd3, 0);

    // Reset while stalled in OUTPUT drops the thread immediately
    out_hold = 1'b0;
    start_thread(9'h1FF, 2'd2);
    for (int i = 0; i < 50 && !output_pc_valid; i++) @(negedge clk);
    check("pre-rst valid", 32'(output_pc_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst outs", 32'({memory_valid, output_pc_valid, accepts, error, accepts_partial}), 32'd0);
    check("midrst pc", 32'(output_pc), 32'd0);
    check("midrst ready", 32'(input_pc_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    out_hold = 1'b1;
    mem[9'h007] = mk(OP_ACCP, 13'h000);
    start_thread(9'h007, 2'd2);
    finish_thread("postrst");
    check_result("postrst", 9'h007, 2'd2, 1, 1, 0, 9'h000, 2'd0, 0);

    // Random single-instruction threads under random back-pressure vs opcode model
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] d, c;
      logic [8:0] pc;
      logic [1:0] cc;
      logic       e, e_acc, e_part, e_fwd, e_err;
      int         k;
      k  = $urandom_range(0, 5);
      op = (k == 5) ? OP_BAD : 3'(k);
      pc = 9'($urandom_range(0, 511));
      cc = 2'($urandom_range(0, 3));
      current_characters = $urandom;
      end_of_string = 4'($urandom_range(0, 15));
      c = current_characters[cc*8 +: 8];
      e = end_of_string[cc];
      d = $urandom_range(0, 1) ? c : 8'($urandom_range(0, 255));
      e_acc = 0; e_part = 0; e_fwd = 0; e_err = 0;
      case (op)
        OP_ACC:    e_acc = e;
        OP_ACCP:   begin e_acc = 1; e_part = 1; end
        OP_MATCH:  e_fwd = !e && (c == d);
        OP_NMATCH: e_fwd = !e && (c != d);
        OP_ANY:    e_fwd = !e;
        default:   e_err = 1;
      endcase
      mem[pc] = mk(op, {5'd0, d});
      start_thread(pc, cc);
      finish_thread($sformatf("rnd%0d", i));
      check_result($sformatf("rnd%0d", i), pc, cc, e_acc, e_part, e_fwd, pc + 9'd1, cc + 2'd1, e_err);
    end
    rand_bp = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_mis);
    $finish;
  end

endmodule
